// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared definitions for the UART receive path: receive word bit
//             positions, IRQ fill-threshold encodings and helper function,
//             default character-timeout length.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receive word layout from the receiver state machine
    localparam int UART_RD_W  = 10;
    localparam int UART_RD_FE = 9;
    localparam int UART_RD_PE = 8;

    // Default idle bit times before a character timeout is flagged
    localparam int UART_TO_BITS_DEF = 40;

    // Receive IRQ fill-threshold select encodings
    typedef enum logic [1:0] {
        LVL_ONE     = 2'd0,
        LVL_QUARTER = 2'd1,
        LVL_HALF    = 2'd2,
        LVL_NFULL   = 2'd3
    } uart_lvl_e;

    // Translate a threshold select into a character count for a given depth
    function automatic int unsigned uart_threshold(input logic [1:0] lvl,
                                                   input int unsigned depth);
        int unsigned thr;
        case (uart_lvl_e'(lvl))
            LVL_ONE:     thr = 1;
            LVL_QUARTER: thr = depth / 4;
            LVL_HALF:    thr = depth / 2;
            LVL_NFULL:   thr = depth - 2;
            default:     thr = 1;
        endcase
        return thr;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo_ram
//  Purpose  : DEPTH x W character storage, synchronous write and
//             asynchronous read, suited to distributed RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Storage write; no reset so the array maps onto RAM primitives
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : uart_fifo_ram
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : Receive-side controller: FWFT character FIFO, sticky
//             overrun/parity/framing status, character-timeout timer and
//             threshold-driven receive interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TO_BITS = UART_TO_BITS_DEF
) (
    input  logic                 Clk,
    input  logic                 nRst,
    input  logic                 CE_16x,
    input  logic [UART_RD_W-1:0] RD,
    input  logic                 WE_RHR,
    input  logic                 RxIdle,
    input  logic                 RE,
    input  logic                 Flush,
    input  logic                 ClrSts,
    input  logic [1:0]           Lvl,
    input  logic                 IE_Err,
    output logic [UART_RD_W-1:0] DO,
    output logic                 RxRdy,
    output logic                 RxFull,
    output logic [AW:0]          Cnt,
    output logic                 OVR,
    output logic                 PES,
    output logic                 FES,
    output logic                 RxTO,
    output logic                 IRQ
);

    localparam int            c_TO_LIMIT = TO_BITS * 16;
    localparam int            TW         = $clog2(c_TO_LIMIT + 1);
    localparam logic [TW-1:0] c_TMR_MAX  = TW'(c_TO_LIMIT);
    localparam logic [TW-1:0] c_TMR_LAST = TW'(c_TO_LIMIT - 1);
    localparam logic [TW-1:0] c_TMR_ONE  = TW'(1);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   c_CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q,    cnt_d;
    logic          ovr_q,    ovr_d;
    logic          pes_q,    pes_d;
    logic          fes_q,    fes_d;
    logic [TW-1:0] tmr_q,    tmr_d;
    logic          rxto_q,   rxto_d;
    logic          irq_q,    irq_d;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_do_write;
    logic                 w_do_read;
    logic                 w_ovr_set;
    logic                 w_tick;
    logic [AW:0]          w_thresh;
    logic [UART_RD_W-1:0] w_ram_rd;

    assign w_empty = (cnt_q == '0);
    assign w_full  = (cnt_q == c_CNT_FULL);

    // A full FIFO still accepts a write when a read frees the head slot in
    // the same cycle; Flush discards everything in its cycle.
    assign w_do_write = WE_RHR & (~w_full | RE) & ~Flush;
    assign w_do_read  = RE & ~w_empty & ~Flush;
    assign w_ovr_set  = WE_RHR & w_full & ~RE & ~Flush;

    // Qualifying timeout tick: data pending, receiver idle, no FIFO activity
    assign w_tick = CE_16x & RxIdle & ~w_empty & ~WE_RHR & ~RE & ~Flush;

    assign w_thresh = (AW+1)'(uart_threshold(Lvl, DEPTH));

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (UART_RD_W)
    ) u_ram (
        .clk_i   (Clk),
        .we_i    (w_do_write),
        .waddr_i (wr_ptr_q),
        .wdata_i (RD),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_ram_rd)
    );

    // Next-state for pointers, count, sticky status, timer and interrupt
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;
        pes_d    = pes_q;
        fes_d    = fes_q;
        tmr_d    = tmr_q;
        rxto_d   = rxto_q;

        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (w_do_write) begin
                wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            end
            if (w_do_read) begin
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            end
            case ({w_do_write, w_do_read})
                2'b10:   cnt_d = cnt_q + c_CNT_ONE;
                2'b01:   cnt_d = cnt_q - c_CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end

        // Clear first so a same-cycle set condition wins
        if (ClrSts) begin
            ovr_d = 1'b0;
            pes_d = 1'b0;
            fes_d = 1'b0;
        end
        if (w_ovr_set) begin
            ovr_d = 1'b1;
        end
        if (w_do_write & RD[UART_RD_PE]) begin
            pes_d = 1'b1;
        end
        if (w_do_write & RD[UART_RD_FE]) begin
            fes_d = 1'b1;
        end

        // Timer saturates at the limit so RxTO stays up until serviced
        if (Flush | WE_RHR | RE | w_empty) begin
            tmr_d = '0;
        end else if (w_tick && (tmr_q != c_TMR_MAX)) begin
            tmr_d = tmr_q + c_TMR_ONE;
        end

        if (Flush | RE | w_empty) begin
            rxto_d = 1'b0;
        end else if (w_tick && (tmr_q == c_TMR_LAST)) begin
            rxto_d = 1'b1;
        end

        irq_d = (cnt_q >= w_thresh) | rxto_q | (IE_Err & (ovr_q | pes_q | fes_q));
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            pes_q    <= 1'b0;
            fes_q    <= 1'b0;
            tmr_q    <= '0;
            rxto_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            pes_q    <= pes_d;
            fes_q    <= fes_d;
            tmr_q    <= tmr_d;
            rxto_q   <= rxto_d;
            irq_q    <= irq_d;
        end
    end

    // Head word is forced to zero while empty so reset presents DO = 0
    assign DO     = w_empty ? '0 : w_ram_rd;
    assign RxRdy  = ~w_empty;
    assign RxFull = w_full;
    assign Cnt    = cnt_q;
    assign OVR    = ovr_q;
    assign PES    = pes_q;
    assign FES    = fes_q;
    assign RxTO   = rxto_q;
    assign IRQ    = irq_q;

endmodule : uart_rx_ctrl
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_ctrl
//  Purpose  : Directed self-checking bench for uart_rx_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    logic       Clk = 1'b0;
    logic       nRst;
    logic       CE_16x;
    logic [9:0] RD;
    logic       WE_RHR;
    logic       RxIdle;
    logic       RE;
    logic       Flush;
    logic       ClrSts;
    logic [1:0] Lvl;
    logic       IE_Err;
    logic [9:0] DO;
    logic       RxRdy;
    logic       RxFull;
    logic [4:0] Cnt;
    logic       OVR;
    logic       PES;
    logic       FES;
    logic       RxTO;
    logic       IRQ;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl #(.DEPTH(16), .AW(4), .TO_BITS(40)) dut (
        .Clk    (Clk),
        .nRst   (nRst),
        .CE_16x (CE_16x),
        .RD     (RD),
        .WE_RHR (WE_RHR),
        .RxIdle (RxIdle),
        .RE     (RE),
        .Flush  (Flush),
        .ClrSts (ClrSts),
        .Lvl    (Lvl),
        .IE_Err (IE_Err),
        .DO     (DO),
        .RxRdy  (RxRdy),
        .RxFull (RxFull),
        .Cnt    (Cnt),
        .OVR    (OVR),
        .PES    (PES),
        .FES    (FES),
        .RxTO   (RxTO),
        .IRQ    (IRQ)
    );

    always #5 Clk = ~Clk;

    // One clock: inputs held across the edge, outputs sampled 1 ns after it
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] d);
        RD = d; WE_RHR = 1'b1;
        cyc();
        WE_RHR = 1'b0;
    endtask

    task automatic rd_one();
        RE = 1'b1;
        cyc();
        RE = 1'b0;
    endtask

    task automatic flush_all();
        Flush = 1'b1; ClrSts = 1'b1;
        cyc();
        Flush = 1'b0; ClrSts = 1'b0;
    endtask

    task automatic test_reset();
        nRst = 1'b0; CE_16x = 1'b0; RD = '0; WE_RHR = 1'b0; RxIdle = 1'b0;
        RE = 1'b0; Flush = 1'b0; ClrSts = 1'b0; Lvl = 2'd3; IE_Err = 1'b0;
        cyc(); cyc();
        checks++;
        if ({Cnt, RxRdy, RxFull, OVR, PES, FES, RxTO, IRQ, DO} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got Cnt=%0d Rdy=%b Full=%b OVR=%b PES=%b FES=%b TO=%b IRQ=%b DO=%h, expected all 0",
                     Cnt, RxRdy, RxFull, OVR, PES, FES, RxTO, IRQ, DO);
        end
        nRst = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        wr(10'h041); wr(10'h042); wr(10'h043);
        checks++;
        if (Cnt !== 5'd3) begin errors++; $display("FAIL basic_cnt: got %0d expected 3", Cnt); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (DO !== 10'h041 + 10'(i)) begin
                errors++; $display("FAIL basic_do%0d: got %h expected %h", i, DO, 10'h041 + 10'(i));
            end
            rd_one();
        end
        checks++;
        if (RxRdy !== 1'b0) begin errors++; $display("FAIL basic_empty: got RxRdy=%b expected 0", RxRdy); end
        // Read on empty is ignored
        rd_one();
        checks++;
        if (Cnt !== 5'd0) begin errors++; $display("FAIL read_empty_cnt: got %0d expected 0", Cnt); end
        // Simultaneous read and write on empty performs the write only
        RE = 1'b1;
        wr(10'h07E);
        RE = 1'b0;
        checks++;
        if (Cnt !== 5'd1 || DO !== 10'h07E) begin
            errors++; $display("FAIL rw_empty: got Cnt=%0d DO=%h expected Cnt=1 DO=07e", Cnt, DO);
        end
        rd_one();
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 16; i++) wr(10'h010 + 10'(i));
        checks++;
        if (Cnt !== 5'd16 || RxFull !== 1'b1 || OVR !== 1'b0) begin
            errors++; $display("FAIL fill: got Cnt=%0d Full=%b OVR=%b expected 16/1/0", Cnt, RxFull, OVR);
        end
        wr(10'h0EE);
        checks++;
        if (Cnt !== 5'd16 || OVR !== 1'b1 || DO !== 10'h010) begin
            errors++; $display("FAIL overrun: got Cnt=%0d OVR=%b DO=%h expected 16/1/010", Cnt, OVR, DO);
        end
        ClrSts = 1'b1; cyc(); ClrSts = 1'b0;
        checks++;
        if (OVR !== 1'b0) begin errors++; $display("FAIL clr_ovr: got %b expected 0", OVR); end
        // Write plus read while full: both happen, no overrun
        RE = 1'b1;
        wr(10'h0AB);
        RE = 1'b0;
        checks++;
        if (Cnt !== 5'd16 || OVR !== 1'b0 || DO !== 10'h011) begin
            errors++; $display("FAIL rw_full: got Cnt=%0d OVR=%b DO=%h expected 16/0/011", Cnt, OVR, DO);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (DO !== ((i < 15) ? 10'h011 + 10'(i) : 10'h0AB)) begin
                errors++; $display("FAIL drain%0d: got %h expected %h", i, DO,
                                   (i < 15) ? 10'h011 + 10'(i) : 10'h0AB);
            end
            rd_one();
        end
        checks++;
        if (RxRdy !== 1'b0 || Cnt !== 5'd0) begin
            errors++; $display("FAIL drain_empty: got Rdy=%b Cnt=%0d expected 0/0", RxRdy, Cnt);
        end
    endtask

    task automatic test_status();
        wr(10'h255); wr(10'h1AA);
        cyc();
        checks++;
        if (FES !== 1'b1 || PES !== 1'b1 || IRQ !== 1'b0 || DO !== 10'h255) begin
            errors++; $display("FAIL err_flags: got FES=%b PES=%b IRQ=%b DO=%h expected 1/1/0/255", FES, PES, IRQ, DO);
        end
        IE_Err = 1'b1;
        cyc();
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL err_irq: got %b expected 1", IRQ); end
        ClrSts = 1'b1;
        wr(10'h1AA);
        ClrSts = 1'b0;
        checks++;
        if (PES !== 1'b1 || FES !== 1'b0) begin
            errors++; $display("FAIL clr_vs_set: got PES=%b FES=%b expected 1/0", PES, FES);
        end
        ClrSts = 1'b1; cyc(); ClrSts = 1'b0;
        checks++;
        if (PES !== 1'b0) begin errors++; $display("FAIL clr_pes: got %b expected 0", PES); end
        IE_Err = 1'b0;
        flush_all();
        cyc();
    endtask

    task automatic test_threshold();
        Lvl = 2'd2;
        for (int i = 0; i < 7; i++) wr(10'h020 + 10'(i));
        cyc();
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL thr_7: got %b expected 0", IRQ); end
        wr(10'h027);
        checks++;
        if (IRQ !== 1'b0 || Cnt !== 5'd8) begin
            errors++; $display("FAIL thr_lag: got IRQ=%b Cnt=%0d expected 0/8", IRQ, Cnt);
        end
        cyc();
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL thr_8: got %b expected 1", IRQ); end
        rd_one();
        cyc();
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL thr_read: got %b expected 0", IRQ); end
        Lvl = 2'd1;
        cyc(); cyc();
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL thr_lvl1: got %b expected 1", IRQ); end
        Lvl = 2'd3;
        cyc(); cyc();
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL thr_lvl3: got %b expected 0", IRQ); end
        flush_all();
        cyc();
    endtask

    task automatic test_timeout();
        wr(10'h061);
        RxIdle = 1'b1; CE_16x = 1'b1;
        repeat (639) cyc();
        checks++;
        if (RxTO !== 1'b0) begin errors++; $display("FAIL to_639: got %b expected 0", RxTO); end
        // A write where the 640th tick would land restarts the count
        wr(10'h062);
        checks++;
        if (RxTO !== 1'b0 || Cnt !== 5'd2) begin
            errors++; $display("FAIL to_restart: got TO=%b Cnt=%0d expected 0/2", RxTO, Cnt);
        end
        repeat (300) cyc();
        RxIdle = 1'b0;
        repeat (50) cyc();
        RxIdle = 1'b1;
        repeat (339) cyc();
        checks++;
        if (RxTO !== 1'b0 || IRQ !== 1'b0) begin
            errors++; $display("FAIL to_pre: got TO=%b IRQ=%b expected 0/0", RxTO, IRQ);
        end
        cyc();
        checks++;
        if (RxTO !== 1'b1) begin errors++; $display("FAIL to_640: got %b expected 1", RxTO); end
        cyc();
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL to_irq: got %b expected 1", IRQ); end
        repeat (5) cyc();
        CE_16x = 1'b0;
        checks++;
        if (RxTO !== 1'b1) begin errors++; $display("FAIL to_hold: got %b expected 1", RxTO); end
        rd_one();
        checks++;
        if (RxTO !== 1'b0 || Cnt !== 5'd1 || DO !== 10'h062) begin
            errors++; $display("FAIL to_clear: got TO=%b Cnt=%0d DO=%h expected 0/1/062", RxTO, Cnt, DO);
        end
        cyc();
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL to_irq_clr: got %b expected 0", IRQ); end
        RxIdle = 1'b0;
        flush_all();
        cyc();
    endtask

    task automatic test_flush_reset();
        wr(10'h001); wr(10'h002); wr(10'h1AA);
        Flush = 1'b1;
        wr(10'h0FF);
        Flush = 1'b0;
        checks++;
        if (Cnt !== 5'd0 || RxRdy !== 1'b0 || PES !== 1'b1) begin
            errors++; $display("FAIL flush: got Cnt=%0d Rdy=%b PES=%b expected 0/0/1", Cnt, RxRdy, PES);
        end
        wr(10'h033);
        checks++;
        if (DO !== 10'h033 || Cnt !== 5'd1) begin
            errors++; $display("FAIL post_flush: got DO=%h Cnt=%0d expected 033/1", DO, Cnt);
        end
        IE_Err = 1'b1;
        RD = 10'h044; WE_RHR = 1'b1;
        repeat (3) cyc();
        checks++;
        if (IRQ !== 1'b1 || Cnt !== 5'd4) begin
            errors++; $display("FAIL burst: got IRQ=%b Cnt=%0d expected 1/4", IRQ, Cnt);
        end
        #3 nRst = 1'b0;
        #1;
        checks++;
        if ({Cnt, RxRdy, RxFull, OVR, PES, FES, RxTO, IRQ, DO} !== 22'd0) begin
            errors++;
            $display("FAIL async_reset: got Cnt=%0d Rdy=%b Full=%b OVR=%b PES=%b FES=%b TO=%b IRQ=%b DO=%h, expected all 0",
                     Cnt, RxRdy, RxFull, OVR, PES, FES, RxTO, IRQ, DO);
        end
        WE_RHR = 1'b0; IE_Err = 1'b0;
        cyc();
        nRst = 1'b1;
        cyc();
        checks++;
        if (Cnt !== 5'd0 || IRQ !== 1'b0) begin
            errors++; $display("FAIL reset_release: got Cnt=%0d IRQ=%b expected 0/0", Cnt, IRQ);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_status();
        test_threshold();
        test_timeout();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_ctrl
`default_nettype wire
